pio_in_edge_irq: RTL and testbench
==================================

// Module: pio_in_edge_irq
// PURPOSE
//  Parametrised Avalon-MM input PIO, successor to the fixed 8-bit data-only input port.
//  Synchronises an external input bus and captures edges per bit in sticky W1C bits.
//  Raises a level IRQ for unmasked captured edges.
//  Sits between board pins (switches/buttons) and the Nios II data bus in the QSYS system.
// PARAMETERS
//  WIDTH           8     input bus width, 1..32 (outside range -> $error at elaboration)
//  SYNC_STAGES     2     flip-flop synchroniser depth, >=2
//  EDGE_TYPE       0     0=rising, 1=falling, 2=any edge
//  RESET_MASK      0     reset value of irqmask register [WIDTH-1:0]
//  DEBOUNCE_CYCLES 1000  stable cycles required before an input change is accepted (DEBOUNCE_EN only)
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  address     in   2      Avalon word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe (qualified by chipselect)
//  writedata   in   32     write data
//  in_port     in   WIDTH  asynchronous external input
//  readdata    out  32     registered read data
//  irq         out  1      level interrupt, active high
// BEHAVIOUR
//  Register map:
//   0 data (RO)
//   1 reserved, reads 0
//   2 irqmask (RW)
//   3 edgecapture (R, W1C)
//  Unused upper bits [31:WIDTH] read 0; writes to RO/reserved addresses are ignored.
//  Reset: sync chain=0, prev=0, edgecapture=0, irqmask=RESET_MASK, readdata=0, irq=0.
//   Reset mid-operation discards any pending edges and debounce progress.
//  Input path: in_port -> SYNC_STAGES FFs -> (debounce) -> "level"; prev <= level each cycle.
//  Edge detect per bit:
//   rise = level & ~prev
//   fall = ~level & prev
//   any  = rise | fall
//   The first cycle after reset compares against prev=0, so a high input at reset yields a rising edge.
//  edgecapture[i] <= (edgecapture[i] & ~clr[i]) | edge[i]
//   clr = writedata bits on a write to address 3.
//   Simultaneous set and clear: set wins (no edge lost).
//  irqmask is written on chipselect & ~write_n & address==2.
//  readdata <= mux(address) every clock, unconditionally.
//   1-cycle read latency; no wait states; reads have no side effects.
//  irq is registered: irq <= |(edgecapture & irqmask) computed from the next-state values, so irq asserts
//   the same cycle edgecapture shows the bit. It deasserts the cycle after a W1C or mask clear.
//  Latency in_port change -> edgecapture set = SYNC_STAGES+1 clocks (no debounce).
//  Pulses shorter than one clk period may be missed; this is by design.
// CONFIGURATION
//  PIO_IN_DEBOUNCE_EN defined:
//   Per-bit counter, $clog2(DEBOUNCE_CYCLES+1) bits.
//   Counter resets to 0 whenever the synced bit equals the debounced level or changes value.
//   The debounced level toggles when the counter reaches DEBOUNCE_CYCLES-1, and the counter saturates/clears.
//   Glitches shorter than DEBOUNCE_CYCLES never reach "level".
//   Added latency = DEBOUNCE_CYCLES clocks.
//  PIO_IN_DEBOUNCE_EN undefined:
//   level = synchroniser output; no counters instantiated; DEBOUNCE_CYCLES is ignored.
// TESTING
//  1) Reset, in_port=0xA5, read addr0 -> readdata=0x000000A5 one clock after the address cycle; addr1 -> 0.
//  2) EDGE_TYPE=0, mask=0x01, in_port 0x00->0x01 -> edgecapture=0x01 and irq=1 after 3 clocks;
//     write 0x01 to addr3 -> edgecapture=0, irq=0 next cycle.
//  3) Rising edge on bit0 in the same cycle as a W1C of bit0 -> edgecapture bit0 stays 1.
//  4) EDGE_TYPE=2, mask=0, toggle bit3 -> edgecapture=0x08, irq stays 0; write mask=0x08 -> irq=1.
//  5) Assert reset while edgecapture=0xFF, mask=0xFF -> next cycle edgecapture=0, irq=0, mask=RESET_MASK.
//  6) PIO_IN_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: a 3-cycle pulse on bit0 -> no capture;
//     a 5-cycle pulse -> edgecapture bit0=1.

Source files
------------

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised input bus, per-bit sticky W1C edge capture, masked level IRQ.
// Optional per-bit debounce filter enabled by defining PIO_IN_DEBOUNCE_EN.
module pio_in_edge_irq #(
    parameter int unsigned     WIDTH           = 8,
    parameter int unsigned     SYNC_STAGES     = 2,
    parameter int unsigned     EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_MASK     = '0,
    parameter int unsigned     DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("pio_in_edge_irq: WIDTH must be within 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pio_in_edge_irq: SYNC_STAGES must be at least 2");
    end
    if (EDGE_TYPE > 2) begin : g_bad_edge
        $error("pio_in_edge_irq: EDGE_TYPE must be 0, 1 or 2");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] synced;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] clr;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_wdata;

    // Upper write data bits beyond WIDTH carry no state.
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PIO_IN_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [WIDTH-1:0][CntW-1:0] cnt_q;
    logic [WIDTH-1:0]           level_q;

    // A bit must disagree with the filtered level for DEBOUNCE_CYCLES cycles in a row to flip it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (synced[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    level_q[i] <= ~level_q[i];
                    cnt_q[i]   <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign level = level_q;
`else
    assign level = synced;
`endif

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        edge_hit = level ^ prev_q;
        if (EDGE_TYPE == 0) begin
            edge_hit = level & ~prev_q;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = ~level & prev_q;
        end
    end

    always_comb begin
        clr        = '0;
        irqmask_d  = irqmask_q;
        readdata_d = '0;
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        // Set wins over a simultaneous clear so no edge is lost.
        edgecap_d = (edgecap_q & ~clr) | edge_hit;
        irq_d     = |(edgecap_d & irqmask_d);
        unique case (address)
            2'd0:    readdata_d[WIDTH-1:0] = level;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            edgecap_q  <= '0;
            irqmask_q  <= RESET_MASK;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= level;
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Bench for pio_in_edge_irq: three instances (rising, falling, any edge) against a history-based model.
module tb_pio_in_edge_irq;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DB   = 4;
    localparam int unsigned NI   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] rd [NI];
    logic        irq_o [NI];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        pio_in_edge_irq #(
            .WIDTH          (8),
            .SYNC_STAGES    (SYNC),
            .EDGE_TYPE      (k),
            .RESET_MASK     ((k == 1) ? 8'h3C : 8'h00),
            .DEBOUNCE_CYCLES(DB)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .address   (address),
            .chipselect(chipselect),
            .write_n   (write_n),
            .writedata (writedata),
            .in_port   (in_port),
            .readdata  (rd[k]),
            .irq       (irq_o[k])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model: delay line of sampled inputs, optional run-length filter, then per-instance registers.
    logic [7:0]  m_hist [SYNC];
    logic [7:0]  m_dlev;
    int          m_run [8];
    logic [7:0]  m_prev [NI];
    logic [7:0]  m_ec [NI];
    logic [7:0]  m_mask [NI];
    logic [31:0] m_rd [NI];
    logic        m_irq [NI];

    function automatic logic [7:0] rmask(input int k);
        return (k == 1) ? 8'h3C : 8'h00;
    endfunction

    task automatic model_step();
        logic [7:0] lev, raw, hit, clr;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_hist[i] = '0;
            m_dlev = '0;
            for (int b = 0; b < 8; b++) m_run[b] = 0;
            for (int k = 0; k < NI; k++) begin
                m_prev[k] = '0; m_ec[k] = '0; m_mask[k] = rmask(k);
                m_rd[k] = '0; m_irq[k] = 1'b0;
            end
            return;
        end
        raw = m_hist[SYNC-1];
`ifdef PIO_IN_DEBOUNCE_EN
        lev = m_dlev;
`else
        lev = raw;
`endif
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
        for (int k = 0; k < NI; k++) begin
            case (address)
                2'd0:    m_rd[k] = {24'h0, lev};
                2'd2:    m_rd[k] = {24'h0, m_mask[k]};
                2'd3:    m_rd[k] = {24'h0, m_ec[k]};
                default: m_rd[k] = 32'h0;
            endcase
            if (k == 0)      hit = lev & ~m_prev[k];
            else if (k == 1) hit = ~lev & m_prev[k];
            else             hit = lev ^ m_prev[k];
            m_ec[k] = (m_ec[k] & ~clr) | hit;
            if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata[7:0];
            m_irq[k] = (m_ec[k] & m_mask[k]) != 0;
            m_prev[k] = lev;
        end
        for (int b = 0; b < 8; b++) begin
            m_run[b] = (raw[b] != m_dlev[b]) ? m_run[b] + 1 : 0;
            if (m_run[b] == DB) begin
                m_dlev[b] = ~m_dlev[b];
                m_run[b] = 0;
            end
        end
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = in_port;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rd%0d", k), rd[k], m_rd[k]);
            check($sformatf("irq%0d", k), {31'h0, irq_o[k]}, {31'h0, m_irq[k]});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        idle(3);
        check("reset_rd", rd[0], 32'h0);
        check("reset_irq", {31'h0, irq_o[0]}, 32'h0);

        // Data read and reserved address.
        reset = 1'b0; in_port = 8'hA5; address = 2'd0;
        idle(12);
        check("data_a5", rd[0], 32'h0000_00A5);
        address = 2'd1;
        idle(1);
        check("reserved", rd[0], 32'h0);

        // Rising edge capture and W1C.
        in_port = 8'h00;
        bus_write(2'd2, 32'h1);
        idle(12);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01; address = 2'd3;
        idle(12);
        check("rise_ec", rd[0], 32'h1);
        check("rise_irq", {31'h0, irq_o[0]}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("w1c_irq", {31'h0, irq_o[0]}, 32'h0);
        idle(1);
        check("w1c_ec", rd[0], 32'h0);

        // Edge coincident with W1C of the same bit.
        in_port = 8'h00;
        idle(12);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        idle(2);
        bus_write(2'd3, 32'h1);
        address = 2'd3;
        idle(12);
        check("set_wins", rd[0], 32'h1);

        // Any-edge capture held off by the mask, then released.
        bus_write(2'd2, 32'h0);
        idle(12);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h09; address = 2'd3;
        idle(12);
        check("any_ec", rd[2], 32'h8);
        check("any_masked", {31'h0, irq_o[2]}, 32'h0);
        bus_write(2'd2, 32'h8);
        check("any_unmask", {31'h0, irq_o[2]}, 32'h1);

        // Reset discards captured edges and restores the mask.
        bus_write(2'd2, 32'hFF);
        in_port = 8'h00;
        idle(12);
        in_port = 8'hFF;
        idle(12);
        reset = 1'b1;
        idle(1);
        check("rst_irq", {31'h0, irq_o[0]}, 32'h0);
        reset = 1'b0; address = 2'd2;
        idle(1);
        check("rst_mask1", rd[1], 32'h3C);
        check("rst_mask0", rd[0], 32'h0);

`ifdef PIO_IN_DEBOUNCE_EN
        // Glitch filter: short pulse rejected, long pulse accepted.
        in_port = 8'h00;
        idle(20);
        bus_write(2'd3, 32'hFF);
        in_port = 8'h01;
        idle(3);
        in_port = 8'h00; address = 2'd3;
        idle(20);
        check("db_short", rd[0], 32'h0);
        in_port = 8'h01;
        idle(5);
        in_port = 8'h00;
        idle(20);
        check("db_long", rd[0], 32'h1);
`endif

        // Randomised traffic, held inputs so debounce sees real edges.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) in_port = 8'($urandom);
            chipselect = ($urandom_range(2) == 0);
            write_n    = ($urandom_range(1) == 0);
            address    = 2'($urandom);
            writedata  = $urandom;
            reset      = ($urandom_range(63) == 0);
            cycle();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
